main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm_if.sv | 33 +++
 rtl/main_control_fsm.sv | 153 +++++++++++++++
 tb/tb_main_control_fsm.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_if.sv
// Control bus between main_control_fsm and the datapath.
// master = controller side, slave = datapath side.
interface main_control_fsm_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ack;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        retire;
  logic        illegal;
  logic [15:0] retired_cnt;

  modport master (
    input  opcode, zero, mem_ack,
    output pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src, alu_src_a,
    output alu_src_b, alu_op, state, retire, illegal, retired_cnt
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src, alu_src_a,
    input  alu_src_b, alu_op, state, retire, illegal, retired_cnt
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle CPU main control FSM: FETCH/DECODE/EXEC/MEM/WB plus terminal ILLEGAL state.
// Define MEM_WAIT_EN to make FETCH and MEM wait for mem_ack.
module main_control_fsm (
  input  logic               clk,
  input  logic               rst,
  main_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExec    = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StIllegal = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsR, ClsI, ClsLw, ClsSw, ClsBeq
  } cls_e;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic        retire_q, retire_d;
  logic [15:0] retired_cnt_q, retired_cnt_d;
  logic        mem_done;

  logic       pc_write, ir_write, mem_read, mem_write;
  logic       reg_write, mem_to_reg, pc_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ack;
`else
  logic unused_mem_ack;
  assign unused_mem_ack = bus.mem_ack;
  assign mem_done       = 1'b1;
`endif

  always_comb begin
    dec_cls = ClsNone;
    case (bus.opcode)
      7'b0110011: dec_cls = ClsR;
      7'b0010011: dec_cls = ClsI;
      7'b0000011: dec_cls = ClsLw;
      7'b0100011: dec_cls = ClsSw;
      7'b1100011: dec_cls = ClsBeq;
      default:    dec_cls = ClsNone;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      cls_q         <= ClsNone;
      retire_q      <= 1'b0;
      retired_cnt_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      retire_q      <= retire_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      StFetch: if (mem_done) state_d = StDecode;
      StDecode: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == ClsNone) ? StIllegal : StExec;
      end
      StExec: begin
        case (cls_q)
          ClsR, ClsI:   state_d = StWb;
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq:       state_d = StFetch;
          default:      state_d = StIllegal;
        endcase
      end
      StMem:     if (mem_done) state_d = (cls_q == ClsLw) ? StWb : StFetch;
      StWb:      state_d = StFetch;
      StIllegal: state_d = StIllegal;
      default:   state_d = StIllegal;
    endcase
    // Retirement is the edge that returns to FETCH after executing an instruction.
    retire_d = (state_d == StFetch) &&
               ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));
    retired_cnt_d = retired_cnt_q + 16'(retire_d);
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    // Reset overrides the FETCH decode so nothing strobes while rst is held.
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_done;
          pc_write  = mem_done;
        end
        StDecode: alu_src_b = 2'b10;
        StExec: begin
          alu_src_a = 1'b1;
          case (cls_q)
            ClsR:         alu_op = 2'b10;
            ClsI:         begin alu_src_b = 2'b10; alu_op = 2'b10; end
            ClsLw, ClsSw: alu_src_b = 2'b10;
            ClsBeq:       begin alu_op = 2'b01; pc_src = 1'b1; pc_write = bus.zero; end
            default:      ;
          endcase
        end
        StMem: begin
          mem_read  = (cls_q == ClsLw);
          mem_write = (cls_q == ClsSw);
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == ClsLw);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ir_write    = ir_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.reg_write   = reg_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.pc_src      = pc_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_op      = alu_op;
  assign bus.state       = state_q;
  assign bus.retire      = retire_q;
  assign bus.illegal     = (state_q == StIllegal) && !rst;
  assign bus.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_main_control_fsm;

  logic clk = 1'b0;
  logic rst;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  strb;  // pc_write ir_write mem_read mem_write reg_write mem_to_reg pc_src alu_src_a
    logic [1:0]  b;
    logic [1:0]  op;
    logic        ret;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [7:0] SFetch = 8'b1110_0000;
  localparam logic [7:0] SExec  = 8'b0000_0001;
  localparam logic [7:0] SBeq1  = 8'b1000_0011;
  localparam logic [7:0] SBeq0  = 8'b0000_0011;
  localparam logic [7:0] SMemR  = 8'b0010_0000;
  localparam logic [7:0] SMemW  = 8'b0001_0000;
  localparam logic [7:0] SWbR   = 8'b0000_1000;
  localparam logic [7:0] SWbL   = 8'b0000_1100;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpBad = 7'b1111111;

  vec_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;
  logic        ret_pend;

  function automatic vec_t mk(logic [2:0] st, logic [7:0] strb, logic [1:0] b, logic [1:0] op,
                              logic ret, logic [15:0] cnt);
    mk = '{st: st, strb: strb, b: b, op: op, ret: ret, ill: (st == 3'd7), cnt: cnt};
  endfunction

  function automatic vec_t actual();
    actual = {bus.state, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
              bus.reg_write, bus.mem_to_reg, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.retire, bus.illegal, bus.retired_cnt};
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push(input string name, input vec_t v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  initial begin
    vec_t  w;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, actual(), w);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    push("reset", mk(3'd0, 8'h00, 2'b00, 2'b00, 1'b0, 16'h0000));
    cyc(1);
    rst      = 1'b0;
    exp_cnt  = 16'h0000;
    ret_pend = 1'b0;
  endtask

  // Opcode is held at a different legal opcode outside DECODE to prove it is ignored there.
  task automatic issue(input string nm, input logic [6:0] op, input logic z);
    int         len;
    logic [6:0] noise;
    noise = (op == OpLw) ? OpSw : OpLw;
    len   = 4;
    push({nm, "_fetch"}, mk(3'd0, SFetch, 2'b01, 2'b00, ret_pend, exp_cnt));
    push({nm, "_decode"}, mk(3'd1, 8'h00, 2'b10, 2'b00, 1'b0, exp_cnt));
    case (op)
      OpR: begin
        push({nm, "_exec"}, mk(3'd2, SExec, 2'b00, 2'b10, 1'b0, exp_cnt));
        push({nm, "_wb"}, mk(3'd4, SWbR, 2'b00, 2'b00, 1'b0, exp_cnt));
      end
      OpI: begin
        push({nm, "_exec"}, mk(3'd2, SExec, 2'b10, 2'b10, 1'b0, exp_cnt));
        push({nm, "_wb"}, mk(3'd4, SWbR, 2'b00, 2'b00, 1'b0, exp_cnt));
      end
      OpLw: begin
        len = 5;
        push({nm, "_exec"}, mk(3'd2, SExec, 2'b10, 2'b00, 1'b0, exp_cnt));
        push({nm, "_mem"}, mk(3'd3, SMemR, 2'b00, 2'b00, 1'b0, exp_cnt));
        push({nm, "_wb"}, mk(3'd4, SWbL, 2'b00, 2'b00, 1'b0, exp_cnt));
      end
      OpSw: begin
        push({nm, "_exec"}, mk(3'd2, SExec, 2'b10, 2'b00, 1'b0, exp_cnt));
        push({nm, "_mem"}, mk(3'd3, SMemW, 2'b00, 2'b00, 1'b0, exp_cnt));
      end
      default: begin
        len = 3;
        push({nm, "_exec"}, mk(3'd2, z ? SBeq1 : SBeq0, 2'b00, 2'b01, 1'b0, exp_cnt));
      end
    endcase
    bus.opcode = noise;
    bus.zero   = ~z;
    cyc(1);
    bus.opcode = op;
    cyc(1);
    bus.opcode = noise;
    bus.zero   = z;
    cyc(1);
    bus.zero = ~z;
    cyc(len - 3);
    ret_pend = 1'b1;
    exp_cnt  = exp_cnt + 16'd1;
  endtask

  initial begin
    vec_t got;
    rst         = 1'b1;
    bus.opcode  = 7'h00;
    bus.zero    = 1'b0;
`ifdef MEM_WAIT_EN
    bus.mem_ack = 1'b1;
`else
    bus.mem_ack = 1'b0;
`endif
    exp_cnt  = 16'h0000;
    ret_pend = 1'b0;
    cyc(1);
    do_reset();

    issue("r", OpR, 1'b0);
    issue("beq_t", OpBeq, 1'b1);
    issue("beq_nt", OpBeq, 1'b0);
    issue("i", OpI, 1'b1);
    issue("lw", OpLw, 1'b0);
    issue("sw", OpSw, 1'b1);

`ifdef MEM_WAIT_EN
    push("lww_fetch", mk(3'd0, SFetch, 2'b01, 2'b00, ret_pend, exp_cnt));
    push("lww_decode", mk(3'd1, 8'h00, 2'b10, 2'b00, 1'b0, exp_cnt));
    push("lww_exec", mk(3'd2, SExec, 2'b10, 2'b00, 1'b0, exp_cnt));
    repeat (4) push("lww_mem", mk(3'd3, SMemR, 2'b00, 2'b00, 1'b0, exp_cnt));
    push("lww_wb", mk(3'd4, SWbL, 2'b00, 2'b00, 1'b0, exp_cnt));
    bus.opcode = OpSw;
    cyc(1);
    bus.opcode = OpLw;
    cyc(1);
    bus.opcode = OpSw;
    cyc(1);
    bus.mem_ack = 1'b0;
    cyc(3);
    bus.mem_ack = 1'b1;
    cyc(2);
    ret_pend = 1'b1;
    exp_cnt  = exp_cnt + 16'd1;
`endif

    // Async reset in the middle of a store's MEM cycle.
    push("arst_fetch", mk(3'd0, SFetch, 2'b01, 2'b00, ret_pend, exp_cnt));
    push("arst_decode", mk(3'd1, 8'h00, 2'b10, 2'b00, 1'b0, exp_cnt));
    push("arst_exec", mk(3'd2, SExec, 2'b10, 2'b00, 1'b0, exp_cnt));
    push("arst_mem", mk(3'd3, SMemW, 2'b00, 2'b00, 1'b0, exp_cnt));
    bus.opcode = OpLw;
    cyc(1);
    bus.opcode = OpSw;
    cyc(1);
    bus.opcode = OpLw;
    cyc(1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = actual();
    check("arst_immediate", got, mk(3'd0, 8'h00, 2'b00, 2'b00, 1'b0, 16'h0000));
    @(posedge clk);
    #1;
    do_reset();
    issue("post_arst", OpR, 1'b0);

    // Illegal opcode locks up until reset.
    push("ill_fetch", mk(3'd0, SFetch, 2'b01, 2'b00, ret_pend, exp_cnt));
    push("ill_decode", mk(3'd1, 8'h00, 2'b10, 2'b00, 1'b0, exp_cnt));
    repeat (20) push("ill_hold", mk(3'd7, 8'h00, 2'b00, 2'b00, 1'b0, exp_cnt));
    bus.opcode = OpR;
    cyc(1);
    bus.opcode = OpBad;
    cyc(1);
    bus.opcode = OpR;
    cyc(20);
    do_reset();
    issue("post_ill", OpI, 1'b0);

    // Counter wrap: preload near the top, then retire stores across 0xFFFF.
    force dut.retired_cnt_q = 16'hfffd;
    #1;
    release dut.retired_cnt_q;
    exp_cnt = 16'hfffd;
    issue("wrap0", OpSw, 1'b0);
    issue("wrap1", OpSw, 1'b0);
    issue("wrap2", OpSw, 1'b0);
    issue("wrap3", OpBeq, 1'b1);

    cyc(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
